// File: rtl/reg_file_bypass.sv
// Register file with two combinational read ports and one synchronous write port.
// Entry 0 is hardwired to zero. A clear sweep zeroes r1..rN-1 after every reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_CLEAR | sweep zeroes one entry per cycle; writes ignored, reads return 0
// S_READY | normal operation; stays here until the next reset
module reg_file_bypass #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_write_addr,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [ADDR_W-1:0] i_read_addr1,
  input  logic [ADDR_W-1:0] i_read_addr2,
  output logic [WIDTH-1:0]  o_data1,
  output logic [WIDTH-1:0]  o_data2,
  output logic              o_ready
);

  localparam int              NUM_REGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FIRST_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [WIDTH-1:0]  regs [1:NUM_REGS-1];
  logic              rd_en;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= FIRST_IDX;
      o_ready <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          // Hold clr_idx at the last entry so the counter never wraps.
          if (clr_idx == LAST_IDX) begin
            state   <= S_READY;
            o_ready <= 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        S_READY: state <= S_READY;
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep is what initialises it.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (state == S_CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (state == S_READY && i_we && i_write_addr != '0) begin
        regs[i_write_addr] <= i_data;
      end
    end
  end

  assign rd_en = i_rst_n && (state == S_READY);

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    if (!rd_en || addr == '0) begin
      val = '0;
    end else if (BYPASS_EN && i_we && addr == i_write_addr) begin
      val = i_data;
    end else begin
      val = regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    o_data1 = read_port(i_read_addr1);
  end

  always_comb begin
    o_data2 = read_port(i_read_addr2);
  end

endmodule

// File: doc/reg_file_bypass.md
Name: reg_file_bypass

Overview:
- Parametrised MIPS-style register file: generic width and depth, two asynchronous read ports, one synchronous write port.
- Adds write-through bypass and a hardware clear sequencer that zeroes every register after reset.
- Sits between the decode stage (read addresses) and the writeback stage (write port).
- o_ready tells the pipeline control when the file is usable after reset.

Parameters:
- WIDTH, 32, data width in bits.
- ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W registers, index 0 hardwired to zero.
- BYPASS_EN, 1, 1 = a read of the register being written in the same cycle returns i_data; 0 = returns stored value.

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_we  in  1  write enable.
- i_write_addr  in  ADDR_W  write address.
- i_data  in  WIDTH  write data, signed.
- i_read_addr1  in  ADDR_W  read port 1 address.
- i_read_addr2  in  ADDR_W  read port 2 address.
- o_data1  out  WIDTH  read port 1 data, signed, combinational.
- o_data2  out  WIDTH  read port 2 data, signed, combinational.
- o_ready  out  1  high when the clear sweep is done and writes are accepted.

Behaviour:
- Reset (i_rst_n low at a rising edge):
  - state <= CLEAR, clr_idx <= 1, o_ready <= 0.
  - Register contents are not touched on the reset edge itself.
- CLEAR state:
  - Each cycle writes 0 to reg[clr_idx] and increments clr_idx.
  - When clr_idx == NUM_REGS-1 is cleared, state <= READY and o_ready <= 1 on that same edge.
  - First cycle with i_rst_n high is sweep cycle 1; o_ready rises after NUM_REGS-1 cycles (31 for the default).
  - i_we is ignored; o_data1/o_data2 are forced to 0 regardless of address.
- Reset asserted mid-sweep: clr_idx returns to 1 and the sweep restarts in full.
- READY state:
  - On a rising edge with i_we=1 and i_write_addr != 0: reg[i_write_addr] <= i_data.
  - A write to address 0 is discarded.
  - The state stays READY until the next reset.
- Reads in READY (combinational, zero latency):
  - If read address == 0: output 0.
  - Else if BYPASS_EN and i_we and read address == i_write_addr: output i_data.
  - Else: output reg[read address].
  - Each port resolves independently; both ports may read the same address.
  - Bypass never applies to address 0, even when i_we=1 and i_write_addr=0.
- No arithmetic: data is passed through at full WIDTH, with no truncation or extension.
- Output values:
  - During reset and CLEAR: o_data1 = o_data2 = 0, o_ready = 0.
  - At power-up, before the first reset: contents and o_ready are undefined. The system must apply reset.
- Storage: NUM_REGS-1 entries (index 0 not stored).
- The clear counter is ADDR_W bits wide and must not wrap past NUM_REGS-1.

Test Plan:
- Reset and clear: hold i_rst_n=0 for 2 cycles, release, with i_we=1, addr 5, data 0xDEAD_BEEF driven throughout -> o_ready low for exactly 31 cycles, then high. Reading addr 5 then returns 0 (write during clear ignored). o_data1/2 are 0 throughout CLEAR.
- Basic write/read: READY; write 0x1234_5678 to r7. Next cycle read r7 on port 1 and port 2 -> both return 0x1234_5678. r8 still reads 0.
- Bypass: BYPASS_EN=1; r9 holds 0x0000_0011; same cycle i_we=1, addr 9, data 0xFFFF_FFFE, read1=9 -> o_data1 = 0xFFFF_FFFE combinationally. With BYPASS_EN=0 the same stimulus returns 0x0000_0011 before the edge and 0xFFFF_FFFE after.
- Zero register: write 0xAAAA_AAAA to addr 0 with read1=0 in the same cycle -> o_data1 = 0 both in that cycle and the next.
- Reset mid-sweep: release reset, re-assert i_rst_n=0 after 10 sweep cycles for 1 cycle, then release -> o_ready rises 31 cycles after the second release, not 21.
- Full sweep coverage: after READY, write 0xFFFF_FFFF to r1..r31, reset, wait for o_ready -> every r1..r31 reads 0. Check r31 explicitly (last index, no wrap).
